// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin owner arbiter for the shared 8:1 x 32-bit mux.
// Ports: clk, rst (sync, active-high), req[7:0], done in; sel[2:0], gnt[7:0],
//   busy, timeout out. Optional watchdog under `MUX8_ARB_WATCHDOG_EN`.
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] gnt_q, gnt_d;
  logic       tmo_q, tmo_d;
  logic [2:0] win;
  logic       rel;
  logic       expire;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_chk
    $error("MAX_HOLD out of range 2..255");
  end

  // First set request strictly after the last owner, wrapping mod 8.
  function automatic logic [2:0] rr_pick(
    input logic [7:0] r,
    input logic [2:0] p
  );
    logic [2:0] w;
    logic [2:0] idx;
    logic       hit;
    w   = p;
    hit = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = p + 3'(i);
      if (!hit && r[idx]) begin
        w   = idx;
        hit = 1'b1;
      end
    end
    return w;
  endfunction

  assign win = rr_pick(req, ptr_q);
  assign rel = done | ~req[sel_q];

`ifdef MUX8_ARB_WATCHDOG_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] cnt_q, cnt_d;

  assign expire = (state_q == OWN) && (cnt_q == HOLD_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = 8'd0;
    end else if (cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = OWN;
          gnt_d   = 8'b1 << win;
          sel_d   = win;
          ptr_d   = win;
        end
      end
      OWN: begin
        // done/drop take precedence: timeout only on a pure watchdog release.
        if (rel || expire) begin
          state_d = IDLE;
          gnt_d   = 8'd0;
          tmo_d   = expire & ~rel;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd7;
      sel_q   <= 3'd0;
      gnt_q   <= 8'd0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign sel     = sel_q;
  assign gnt     = gnt_q;
  assign busy    = |gnt_q;
  assign timeout = tmo_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: directed bench for mux8_rr_arbiter.
// Covers reset, rotation, wrap priority, drop, watchdog, mid-grant reset.
module tb_mux8_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       busy;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .gnt     (gnt),
    .busy    (busy),
    .timeout (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [7:0] eg,
                        input logic [2:0] es, input logic et);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".sel"}, 32'(sel), 32'(es));
    chk({tag, ".busy"}, 32'(busy), 32'(eg != 8'd0));
    chk({tag, ".tmo"}, 32'(timeout), 32'(et));
  endtask

  initial begin
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;
    tick();
    tick();
    chk_st("reset", 8'h00, 3'd0, 1'b0);

    rst = 1'b0;
    req = 8'h01;
    tick();
    chk_st("first", 8'h01, 3'd0, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_st("first_rel", 8'h00, 3'd0, 1'b0);

    req = 8'hFF;
    for (int k = 1; k <= 8; k++) begin
      logic [2:0] o;
      o = 3'(k % 8);
      tick();
      chk_st($sformatf("rot%0d", k), 8'b1 << o, o, 1'b0);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk_st($sformatf("rot%0d_gap", k), 8'h00, o, 1'b0);
    end

    req = 8'h40;
    tick();
    chk_st("own6", 8'h40, 3'd6, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_st("rel6", 8'h00, 3'd6, 1'b0);
    req = 8'h41;
    tick();
    chk_st("wrap0", 8'h01, 3'd0, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_st("wrap_gap", 8'h00, 3'd0, 1'b0);
    tick();
    chk_st("wrap6", 8'h40, 3'd6, 1'b0);
    req  = 8'h00;
    done = 1'b1;
    tick();
    done = 1'b0;

    req = 8'h08;
    tick();
    chk_st("own3", 8'h08, 3'd3, 1'b0);
    req = 8'h00;
    tick();
    chk_st("drop3", 8'h00, 3'd3, 1'b0);
    req = 8'h08;
    tick();
    chk_st("own3b", 8'h08, 3'd3, 1'b0);
    req  = 8'h00;
    done = 1'b1;
    tick();
    chk_st("dropdone", 8'h00, 3'd3, 1'b0);
    tick();
    chk_st("idle_done", 8'h00, 3'd3, 1'b0);
    done = 1'b0;

    req = 8'h0C;
    tick();
    chk_st("wd_own2", 8'h04, 3'd2, 1'b0);
`ifdef MUX8_ARB_WATCHDOG_EN
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk_st($sformatf("wd_hold%0d", c), 8'h04, 3'd2, 1'b0);
    end
    tick();
    chk_st("wd_expire", 8'h00, 3'd2, 1'b1);
    tick();
    chk_st("wd_next3", 8'h08, 3'd3, 1'b0);
`else
    for (int c = 2; c <= 55; c++) begin
      tick();
      chk_st($sformatf("wd_off%0d", c), 8'h04, 3'd2, 1'b0);
    end
`endif
    req = 8'h00;
    tick();
    chk("wd_rel", 32'(gnt), 32'h0);

    req = 8'h20;
    tick();
    chk_st("own5", 8'h20, 3'd5, 1'b0);
    rst = 1'b1;
    tick();
    chk_st("mid_rst", 8'h00, 3'd0, 1'b0);
    rst = 1'b0;
    req = 8'h60;
    tick();
    chk_st("post_rst", 8'h20, 3'd5, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and sequencer for the shared 8-input, 32-bit select mux in the datapath. It lets up to eight requesters take turns on the shared 32-bit bus. It produces the 3-bit mux select plus a one-hot grant, and holds ownership until the owner signals completion. An optional watchdog forcibly revokes an overlong grant.

## Interface
Parameters:
- MAX_HOLD, default 16: maximum cycles one owner may hold the bus. Used only when the watchdog is compiled in; legal range 2..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- req  input  8  request line per requester; bit i = requester i
- done  input  1  current owner has finished; release the bus
- sel  output  3  mux select; binary index of current/last owner; drives the mux S input
- gnt  output  8  one-hot grant; all-zero when no owner
- busy  output  1  1 while a grant is active (gnt != 0)
- timeout  output  1  one-cycle pulse on watchdog-forced release; constant 0 when watchdog compiled out

## Operation
- Internal state:
  - 2-state FSM: IDLE, OWN.
  - 3-bit last-owner pointer `ptr`.
  - Hold counter, 8 bits.
- IDLE:
  - If req != 0, select the winner: the first set bit searching from index ptr+1 upward, mod 8.
  - Next cycle: gnt = one-hot(winner), sel = winner, ptr = winner, counter = 0, state OWN.
  - If req == 0, stay IDLE; gnt = 0; sel holds its last value.
- OWN: release when any of the following holds:
  - done = 1;
  - req[owner] = 0 (requester dropped);
  - watchdog expiry (counter == MAX_HOLD-1 with done = 0).
- Release effect, next cycle:
  - gnt = 0, busy = 0, state IDLE.
  - sel unchanged; ptr stays at the released owner.
- Simultaneous release conditions produce a single release.
  - timeout pulses only if expiry occurred and done = 0 and req[owner] = 1.
- Other requests during OWN:
  - No preemption.
  - New requests wait and are arbitrated in IDLE.
- done while IDLE is ignored.
- Counter:
  - Increments each OWN cycle.
  - Saturates; never wraps.
- Reset values: gnt = 0, sel = 0, busy = 0, timeout = 0, ptr = 7 (requester 0 first), counter = 0, state IDLE.
- Reset mid-grant aborts ownership immediately. No timeout pulse.

## Timing
- Grant latency:
  - req sampled in IDLE at edge N → gnt/sel valid after edge N+1.
  - Owner may use the bus from that cycle.
- Release latency: done/drop sampled at edge M → gnt = 0 after edge M+1.
- Back-to-back grants are separated by exactly one idle cycle (gnt = 0).
  - Continuous ownership therefore yields at most one handover per 2 cycles.
- sel is registered and changes only on the grant edge, so the mux output is glitch-free during ownership.
- Watchdog:
  - Owner holds gnt for exactly MAX_HOLD cycles.
  - timeout is high during the first cycle with gnt = 0 after a forced release.
- No combinational path from req/done to any output.

## Configuration
- MUX8_ARB_WATCHDOG_EN defined:
  - Hold counter compared against MAX_HOLD.
  - Expiry forces release and pulses timeout.
- Not defined:
  - Counter and compare removed.
  - Ownership lasts until done or drop, indefinitely.
  - timeout tied to 0.

## Test plan
- Reset/first grant:
  - rst = 1 for 2 cycles → gnt = 0, sel = 0, busy = 0.
  - Then req = 8'h01 → after one edge, gnt = 8'h01, sel = 0, busy = 1.
- Full rotation:
  - req = 8'hFF held, done pulsed 1 cycle after each grant.
  - → grants to 0,1,…,7,0 in order; sel 0..7,0; one gnt = 0 cycle between each.
- Wrap-around priority:
  - Grant and release requester 6, then req = 8'h41 → gnt = 8'h01, sel = 0 (not 6).
  - Next release → gnt = 8'h40.
- Drop and simultaneous events:
  - Owner 3 lowers req[3] with done = 0 → gnt = 0 next cycle.
  - done asserted together with drop → single release, timeout = 0.
  - done during IDLE → no effect.
- Watchdog (macro on, MAX_HOLD = 4):
  - req = 8'h0C, owner 2 never asserts done → gnt = 8'h04 for exactly 4 cycles.
  - Then timeout = 1 for one cycle with gnt = 0.
  - Then gnt = 8'h08.
  - With macro off: gnt = 8'h04 persists for 50+ cycles, timeout = 0.
- Reset mid-operation:
  - rst = 1 while owner 5 holds → next edge gnt = 0, sel = 0, timeout = 0.
  - After rst release with req = 8'h60 → gnt = 8'h20 (ptr back to 7).
